id_hazard_ctrl: RTL and testbench

//  Decode-stage hazard/sequencing controller, directly upstream of the ID/EX pipeline register.

---
 rtl/id_hazard_ctrl.sv | 110 +++++++++++
 tb/tb_id_hazard_ctrl.sv | 143 ++++++++++++++
 2 files changed

// File: rtl/id_hazard_ctrl.sv
// id_hazard_ctrl: decode-stage load-use stall, control-op fetch freeze and HALT drain sequencing
module id_hazard_ctrl #(
    parameter int REG_W        = 4,
    parameter int DRAIN_CYCLES = 3,
    parameter int CTRL_TIMEOUT = 7
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             id_valid,
    input  logic [REG_W-1:0] id_rs1,
    input  logic             id_rs1_used,
    input  logic [REG_W-1:0] id_rs2,
    input  logic             id_rs2_used,
    input  logic             id_ctrl,
    input  logic             id_halt,
    input  logic             ex_mem_read,
    input  logic [REG_W-1:0] ex_reg_rd,
    input  logic             ex_ctrl_resolved,
    output logic             pc_stall,
    output logic             ifid_stall,
    output logic             ifid_flush,
    output logic             idex_bubble,
    output logic             PC_hazard,
    output logic             halted,
    output logic             ctrl_timeout
);
    localparam int WW = $clog2(CTRL_TIMEOUT + 1);
    localparam int DW = DRAIN_CYCLES > 1 ? $clog2(DRAIN_CYCLES) : 1;

    typedef enum logic [1:0] {RUN, CTRL_WAIT, DRAIN, HALTED} state_t;

    state_t         state, state_nx;
    logic [WW-1:0]  wait_cnt, wait_nx;
    logic [DW-1:0]  drain_cnt, drain_nx;
    logic           timeout_nx;
    logic           lu;

    assign lu = id_valid & ex_mem_read & (ex_reg_rd != '0) &
                ((id_rs1_used & (id_rs1 == ex_reg_rd)) | (id_rs2_used & (id_rs2 == ex_reg_rd)));
    assign halted = state == HALTED;

    always_comb begin
        state_nx    = state;
        wait_nx     = wait_cnt;
        drain_nx    = drain_cnt;
        timeout_nx  = ctrl_timeout;
        pc_stall    = 1'b0;
        ifid_stall  = 1'b0;
        ifid_flush  = 1'b0;
        idex_bubble = 1'b0;
        PC_hazard   = 1'b0;
        case (state)
            RUN: begin
                // A load-use stall holds the instruction, so its ctrl/halt is seen again next cycle
                if (lu) begin
                    pc_stall    = 1'b1;
                    ifid_stall  = 1'b1;
                    idex_bubble = 1'b1;
                end else if (id_valid & id_halt) begin
                    state_nx = DRAIN;
                    drain_nx = DW'(DRAIN_CYCLES - 1);
                end else if (id_valid & id_ctrl) begin
                    state_nx = CTRL_WAIT;
                    wait_nx  = '0;
                end
            end
            CTRL_WAIT: begin
                pc_stall    = 1'b1;
                ifid_flush  = 1'b1;
                idex_bubble = 1'b1;
                PC_hazard   = 1'b1;
                if (ex_ctrl_resolved) begin
                    state_nx = RUN;
                end else if (wait_cnt == WW'(CTRL_TIMEOUT - 1)) begin
                    state_nx   = RUN;
                    timeout_nx = 1'b1;
                    wait_nx    = WW'(CTRL_TIMEOUT);
                end else begin
                    wait_nx = wait_cnt != WW'(CTRL_TIMEOUT) ? wait_cnt + 1'b1 : wait_cnt;
                end
            end
            DRAIN: begin
                pc_stall    = 1'b1;
                ifid_flush  = 1'b1;
                idex_bubble = 1'b1;
                state_nx    = drain_cnt == '0 ? HALTED : DRAIN;
                drain_nx    = drain_cnt == '0 ? drain_cnt : drain_cnt - 1'b1;
            end
            default: begin
                pc_stall    = 1'b1;
                ifid_flush  = 1'b1;
                idex_bubble = 1'b1;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state        <= RUN;
            wait_cnt     <= '0;
            drain_cnt    <= '0;
            ctrl_timeout <= 1'b0;
        end else begin
            state        <= state_nx;
            wait_cnt     <= wait_nx;
            drain_cnt    <= drain_nx;
            ctrl_timeout <= timeout_nx;
        end
    end
endmodule

// File: tb/tb_id_hazard_ctrl.sv
// tb_id_hazard_ctrl: directed and random stimulus checked against an age-based reference model
module tb_id_hazard_ctrl;
    localparam int DC = 3;
    localparam int CT = 7;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic       rst, id_valid, id_rs1_used, id_rs2_used, id_ctrl, id_halt, ex_mem_read, ex_ctrl_resolved;
    logic [3:0] id_rs1, id_rs2, ex_reg_rd;
    logic       pc_stall, ifid_stall, ifid_flush, idex_bubble, PC_hazard, halted, ctrl_timeout;

    id_hazard_ctrl #(.REG_W(4), .DRAIN_CYCLES(DC), .CTRL_TIMEOUT(CT)) dut (
        .clk(clk), .rst(rst), .id_valid(id_valid), .id_rs1(id_rs1), .id_rs1_used(id_rs1_used),
        .id_rs2(id_rs2), .id_rs2_used(id_rs2_used), .id_ctrl(id_ctrl), .id_halt(id_halt),
        .ex_mem_read(ex_mem_read), .ex_reg_rd(ex_reg_rd), .ex_ctrl_resolved(ex_ctrl_resolved),
        .pc_stall(pc_stall), .ifid_stall(ifid_stall), .ifid_flush(ifid_flush), .idex_bubble(idex_bubble),
        .PC_hazard(PC_hazard), .halted(halted), .ctrl_timeout(ctrl_timeout)
    );

    int checks = 0;
    int errors = 0;
    // Model: cycles spent waiting on a control op / since HALT left ID (0 = not in that phase)
    int ctrl_age = 0;
    int halt_age = 0;
    bit tmo = 1'b0;
    logic [6:0] obs;

    task automatic check(input string tag, input logic [6:0] got, input logic [6:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got=%b exp=%b", tag, got, exp);
        end
    endtask

    function automatic bit load_use();
        return id_valid && ex_mem_read && ex_reg_rd != 0 &&
               ((id_rs1_used && id_rs1 == ex_reg_rd) || (id_rs2_used && id_rs2 == ex_reg_rd));
    endfunction

    // {pc_stall, ifid_stall, ifid_flush, idex_bubble, PC_hazard, halted, ctrl_timeout}
    function automatic logic [6:0] model_out();
        bit l = load_use();
        if (halt_age > 0) return {1'b1, 1'b0, 1'b1, 1'b1, 1'b0, halt_age > DC, tmo};
        if (ctrl_age > 0) return {1'b1, 1'b0, 1'b1, 1'b1, 1'b1, 1'b0, tmo};
        return {l, l, 1'b0, l, 1'b0, 1'b0, tmo};
    endfunction

    task automatic step(input logic r, input logic v, input logic [3:0] a, input logic ua,
                        input logic [3:0] b, input logic ub, input logic c, input logic h,
                        input logic m, input logic [3:0] d, input logic res);
        rst = r; id_valid = v; id_rs1 = a; id_rs1_used = ua; id_rs2 = b; id_rs2_used = ub;
        id_ctrl = c; id_halt = h; ex_mem_read = m; ex_reg_rd = d; ex_ctrl_resolved = res;
        @(negedge clk);
        obs = {pc_stall, ifid_stall, ifid_flush, idex_bubble, PC_hazard, halted, ctrl_timeout};
        check("cycle", obs, model_out());
        @(posedge clk);
        if (r) begin
            ctrl_age = 0; halt_age = 0; tmo = 1'b0;
        end else if (halt_age > 0) begin
            halt_age = halt_age > DC ? halt_age : halt_age + 1;
        end else if (ctrl_age > 0) begin
            if (res || ctrl_age == CT) begin
                tmo = tmo | !res;
                ctrl_age = 0;
            end else ctrl_age++;
        end else if (v && !load_use()) begin
            if (h) halt_age = 1;
            else if (c) ctrl_age = 1;
        end
        #1;
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) step(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
    endtask

    initial begin
        {rst, id_valid, id_rs1_used, id_rs2_used, id_ctrl, id_halt, ex_mem_read, ex_ctrl_resolved} = 8'h80;
        {id_rs1, id_rs2, ex_reg_rd} = '0;
        @(posedge clk); #1;
        step(1, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
        idle(1);
        check("reset", obs, 7'b0);
        // load-use on rs1, then the bubble has cleared ex_mem_read
        step(0, 1, 3, 1, 0, 0, 0, 0, 1, 3, 0);
        check("lu_stall", obs, 7'b1101000);
        step(0, 1, 3, 1, 0, 0, 0, 0, 0, 3, 0);
        check("lu_release", obs, 7'b0);
        step(0, 1, 0, 1, 0, 0, 0, 0, 1, 0, 0);
        check("r0_no_hazard", obs, 7'b0);
        step(0, 1, 0, 0, 5, 0, 0, 0, 1, 5, 0);
        check("rs2_unused", obs, 7'b0);
        // call resolved on third wait cycle
        step(0, 1, 1, 0, 2, 0, 1, 0, 0, 0, 0);
        idle(2);
        check("ctrl_wait", obs, 7'b1011100);
        step(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 1);
        check("ctrl_resolve_cycle", obs, 7'b1011100);
        idle(1);
        check("ctrl_back_run", obs, 7'b0);
        // unresolved branch times out
        step(0, 1, 1, 0, 2, 0, 1, 0, 0, 0, 0);
        idle(CT);
        check("ctrl_wait_last", obs, 7'b1011100);
        idle(1);
        check("timeout_set", obs, 7'b0000001);
        idle(3);
        check("timeout_sticky", obs, 7'b0000001);
        step(1, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
        idle(1);
        check("timeout_cleared", obs, 7'b0);
        // HALT drain then halted
        step(0, 1, 0, 0, 0, 0, 0, 1, 0, 0, 0);
        idle(DC);
        check("drain", obs, 7'b1011000);
        for (int i = 0; i < 20; i++) begin
            idle(1);
            check("halted", obs, 7'b1011010);
        end
        step(1, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
        idle(1);
        check("halt_reset", obs, 7'b0);
        // load-use on a branch, then wait, then reset mid-wait
        step(0, 1, 4, 1, 0, 0, 1, 0, 1, 4, 0);
        check("lu_branch_stall", obs, 7'b1101000);
        step(0, 1, 4, 1, 0, 0, 1, 0, 0, 4, 0);
        check("lu_branch_enter", obs, 7'b0);
        idle(1);
        check("lu_branch_wait", obs, 7'b1011100);
        step(1, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
        idle(1);
        check("wait_reset", obs, 7'b0);
        for (int i = 0; i < 800; i++)
            step($urandom_range(0, 49) == 0, 1'($urandom), 4'($urandom_range(0, 3)), 1'($urandom),
                 4'($urandom_range(0, 3)), 1'($urandom), $urandom_range(0, 4) == 0,
                 $urandom_range(0, 24) == 0, 1'($urandom), 4'($urandom_range(0, 3)),
                 $urandom_range(0, 5) == 0);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
